// File: rtl/riscv_proc_wb_arbiter_rr_pkg.sv
// rtl/riscv_proc_wb_arbiter_rr_pkg.sv - sel encoding and width helper shared by the arbiter and writeback mux
package riscv_proc_wb_arbiter_rr_pkg;

  localparam int SEL_DMEM      = 0;
  localparam int SEL_CH_OFFSET = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/riscv_rr_prio_pick.sv
// rtl/riscv_rr_prio_pick.sv - one-hot priority picker searching upward from a start index with wrap
module riscv_rr_prio_pick
  import riscv_proc_wb_arbiter_rr_pkg::*;
#(
  parameter  int N  = 3,
  localparam int PW = (N > 1) ? clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] start,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, start} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/riscv_proc_wb_arbiter_rr.sv
// rtl/riscv_proc_wb_arbiter_rr.sv - register-file write port arbiter: dmem first, then urgent, then fixed/RR queues
module riscv_proc_wb_arbiter_rr
  import riscv_proc_wb_arbiter_rr_pkg::*;
#(
  parameter  int NCH          = 3,
  parameter  int RR_MODE      = 0,
  parameter  int STARVE_LIMIT = 7,
  localparam int SELW         = clog2(NCH + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            dmem_resp_val,
  input  logic [NCH-1:0]  q_deq_val,
  output logic [NCH-1:0]  q_deq_rdy,
  output logic [SELW-1:0] sel,
  output logic            wb_val,
  output logic            urgent_grant
);

  localparam int PW = (NCH > 1) ? clog2(NCH) : 1;

  logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
  logic           urgent_grant_q, urgent_grant_d;
  logic [NCH-1:0] urgent_vec;

  logic [NCH-1:0] urg_gnt, norm_gnt;
  logic [PW-1:0]  urg_idx, norm_idx, norm_start;
  logic           urg_any, norm_any;
  logic [PW-1:0]  gnt_idx;
  logic           gnt_any;

  assign norm_start = (RR_MODE != 0) ? rr_ptr_q : '0;

  riscv_rr_prio_pick #(.N(NCH)) u_pick_urg (
    .req     (urgent_vec),
    .start   ('0),
    .gnt     (urg_gnt),
    .gnt_idx (urg_idx),
    .any     (urg_any)
  );

  riscv_rr_prio_pick #(.N(NCH)) u_pick_norm (
    .req     (q_deq_val),
    .start   (norm_start),
    .gnt     (norm_gnt),
    .gnt_idx (norm_idx),
    .any     (norm_any)
  );

  // Outputs are forced idle while reset_n is low, independent of the clock.
  always_comb begin
    q_deq_rdy      = '0;
    sel            = SELW'(SEL_DMEM);
    wb_val         = 1'b0;
    rr_ptr_d       = rr_ptr_q;
    urgent_grant_d = 1'b0;
    gnt_idx        = '0;
    gnt_any        = 1'b0;
    if (reset_n) begin
      if (dmem_resp_val) begin
        wb_val = 1'b1;
      end else if (urg_any) begin
        q_deq_rdy      = urg_gnt;
        gnt_idx        = urg_idx;
        gnt_any        = 1'b1;
        urgent_grant_d = 1'b1;
      end else if (norm_any) begin
        q_deq_rdy = norm_gnt;
        gnt_idx   = norm_idx;
        gnt_any   = 1'b1;
      end
      if (gnt_any) begin
        wb_val = 1'b1;
        sel    = SELW'(gnt_idx) + SELW'(SEL_CH_OFFSET);
        if (RR_MODE != 0 && NCH > 1)
          rr_ptr_d = (gnt_idx == PW'(NCH - 1)) ? '0 : gnt_idx + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q       <= '0;
      urgent_grant_q <= 1'b0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      urgent_grant_q <= urgent_grant_d;
    end
  end

  assign urgent_grant = urgent_grant_q;

  if (STARVE_LIMIT > 0) begin : g_age
    localparam int AW = clog2(STARVE_LIMIT + 1);
    logic [AW-1:0] age_q [NCH];
    logic [AW-1:0] age_d [NCH];

    always_comb begin
      urgent_vec = '0;
      for (int i = 0; i < NCH; i++)
        urgent_vec[i] = q_deq_val[i] && (age_q[i] == AW'(STARVE_LIMIT));
    end

    // Blocked-and-valid ages up (saturating); anything else restarts the count.
    always_comb begin
      for (int i = 0; i < NCH; i++) begin
        age_d[i] = '0;
        if (q_deq_val[i] && !q_deq_rdy[i])
          age_d[i] = (age_q[i] == AW'(STARVE_LIMIT)) ? age_q[i] : age_q[i] + AW'(1);
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < NCH; i++) age_q[i] <= '0;
      end else begin
        for (int i = 0; i < NCH; i++) age_q[i] <= age_d[i];
      end
    end
  end else begin : g_no_age
    assign urgent_vec = '0;
  end

endmodule
